// File: rtl/z80_bus_ctrl_pkg.sv
// Types and constants shared by the Z80 bus-control shell.
package z80_bus_ctrl_pkg;

`include "z80_bus_defs.vh"

    localparam int WAIT_W = 4;

    typedef enum logic {
        ACK_IDLE,
        ACK_HOLD
    } ack_state_t;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic io_rd;
        logic io_wr;
    } bus_acc_t;

endpackage

// File: rtl/z80_bus_defs.vh
// Shared constants and the channel priority encoder for the Z80 bus shell.
`ifndef Z80_BUS_DEFS_VH
`define Z80_BUS_DEFS_VH

localparam int IRQ_MODE_IM1 = 1;
localparam int IRQ_MODE_IM2 = 2;

localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

typedef struct packed {
    logic       hit;
    logic [2:0] idx;
} prio_t;

// Lowest set bit wins, so channel 0 has the highest priority.
function automatic prio_t prio_enc(input logic [7:0] v);
    prio_t r;
    r.hit = |v;
    r.idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
        if (v[i]) r.idx = 3'(i);
    end
    return r;
endfunction

`endif

// File: rtl/z80_irq_ctrl.sv
// Latched, masked, priority interrupt controller with IM1/IM2 vectoring.
module z80_irq_ctrl #(
    parameter int         NUM_IRQ  = 4,
    parameter int         IRQ_MODE = 1,
    parameter logic [7:0] VEC_BASE = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               intack,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic               int_n,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [7:0]         vector
);
    import z80_bus_ctrl_pkg::*;

    ack_state_t         state;
    ack_state_t         state_nxt;
    logic               first;
    logic [NUM_IRQ-1:0] req_prev;
    logic [NUM_IRQ-1:0] req_edge;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] qual;
    logic [NUM_IRQ-1:0] clr;
    logic [7:0]         qual8;
    logic [7:0]         vec_nxt;
    logic [7:0]         vec_q;
    prio_t              win;

    assign req_edge = irq_req & ~req_prev;
    assign qual     = pending & irq_en;

    always_comb begin
        qual8 = '0;
        qual8[NUM_IRQ-1:0] = qual;
    end

    assign win = prio_enc(qual8);

    always_comb begin
        state_nxt = state;
        first     = 1'b0;
        unique case (state)
            ACK_IDLE: begin
                if (intack) begin
                    state_nxt = ACK_HOLD;
                    first     = 1'b1;
                end
            end
            ACK_HOLD: begin
                if (!intack) state_nxt = ACK_IDLE;
            end
            default: state_nxt = ACK_IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = first & win.hit & (win.idx == 3'(i));
        end
    end

    always_comb begin
        vec_nxt = SPURIOUS_VEC;
        if (IRQ_MODE == IRQ_MODE_IM1) begin
            vec_nxt = SPURIOUS_VEC;
        end else if (win.hit) begin
            vec_nxt = VEC_BASE + {4'b0000, win.idx, 1'b0};
        end
    end

    // The first intack clock has no latched vector yet, so drive it live.
    assign vector = first ? vec_nxt : vec_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ACK_IDLE;
            req_prev <= '0;
            pending  <= '0;
            irq_ack  <= '0;
            int_n    <= 1'b1;
            vec_q    <= SPURIOUS_VEC;
        end else begin
            state    <= state_nxt;
            req_prev <= irq_req;
            pending  <= (pending & ~clr) | req_edge;
            irq_ack  <= clr;
            int_n    <= ~|qual;
            if (first) vec_q <= vec_nxt;
        end
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// Bus-control shell between a T80 core and board logic: qualified
// access levels/strobes, wait-state insertion and interrupt vectoring.
module z80_bus_ctrl #(
    parameter int         NUM_IRQ  = 4,
    parameter int         IRQ_MODE = 1,
    parameter logic [7:0] VEC_BASE = 8'h00,
    parameter int         WAIT_MEM = 0,
    parameter int         WAIT_IO  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_mreq_n,
    input  logic               cpu_iorq_n,
    input  logic               cpu_rd_n,
    input  logic               cpu_wr_n,
    input  logic               cpu_rfsh_n,
    input  logic               cpu_m1_n,
    input  logic [15:0]        cpu_adr,
    input  logic [7:0]         cpu_do,
    output logic [7:0]         cpu_di,
    output logic               cpu_int_n,
    output logic               cpu_wait_n,
    input  logic               pause,
    output logic [15:0]        adr,
    output logic [7:0]         data_out,
    input  logic [7:0]         data_in,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               io_rd,
    output logic               io_wr,
    output logic               mem_rd_stb,
    output logic               mem_wr_stb,
    output logic               io_rd_stb,
    output logic               io_wr_stb,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic [NUM_IRQ-1:0] irq_ack
);
    import z80_bus_ctrl_pkg::*;

    localparam logic [WAIT_W-1:0] WAIT_M = WAIT_W'(WAIT_MEM);
    localparam logic [WAIT_W-1:0] WAIT_I = WAIT_W'(WAIT_IO);

    bus_acc_t          acc;
    bus_acc_t          acc_prev;
    bus_acc_t          stb;
    logic              intack;
    logic              mem_stb;
    logic              io_stb;
    logic              wait_req;
    logic [WAIT_W-1:0] wait_sel;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [7:0]        vector;

    assign adr      = cpu_adr;
    assign data_out = cpu_do;

    assign intack = reset_n & ~cpu_iorq_n & ~cpu_m1_n;

    // Gating with reset_n makes a mid-access reset drop every output at once.
    always_comb begin
        acc = '0;
        if (reset_n) begin
            acc.mem_rd = ~cpu_mreq_n & cpu_rfsh_n & ~cpu_rd_n;
            acc.mem_wr = ~cpu_mreq_n & cpu_rfsh_n & ~cpu_wr_n;
            acc.io_rd  = ~cpu_iorq_n & cpu_m1_n & ~cpu_rd_n;
            acc.io_wr  = ~cpu_iorq_n & cpu_m1_n & ~cpu_wr_n;
        end
    end

    assign stb = acc & ~acc_prev;

    assign mem_rd     = acc.mem_rd;
    assign mem_wr     = acc.mem_wr;
    assign io_rd      = acc.io_rd;
    assign io_wr      = acc.io_wr;
    assign mem_rd_stb = stb.mem_rd;
    assign mem_wr_stb = stb.mem_wr;
    assign io_rd_stb  = stb.io_rd;
    assign io_wr_stb  = stb.io_wr;

    assign mem_stb = stb.mem_rd | stb.mem_wr;
    assign io_stb  = stb.io_rd | stb.io_wr;

    always_comb begin
        wait_sel = '0;
        unique case (1'b1)
            mem_stb: wait_sel = WAIT_M;
            io_stb:  wait_sel = WAIT_I;
            default: wait_sel = '0;
        endcase
    end

    // The strobe clock itself is the first wait clock, hence the -1 on load.
    always_comb begin
        wait_nxt = '0;
        if (wait_sel != '0) begin
            wait_nxt = wait_sel - 1'b1;
        end else if (wait_cnt != '0) begin
            wait_nxt = wait_cnt - 1'b1;
        end
    end

    assign wait_req   = pause | (wait_sel != '0) | (wait_cnt != '0);
    assign cpu_wait_n = ~(reset_n & wait_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_prev <= '0;
            wait_cnt <= '0;
        end else begin
            acc_prev <= acc;
            wait_cnt <= wait_nxt;
        end
    end

    z80_irq_ctrl #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_MODE (IRQ_MODE),
        .VEC_BASE (VEC_BASE)
    ) u_irq (
        .clk     (clk),
        .reset_n (reset_n),
        .intack  (intack),
        .irq_req (irq_req),
        .irq_en  (irq_en),
        .int_n   (cpu_int_n),
        .irq_ack (irq_ack),
        .vector  (vector)
    );

    assign cpu_di = intack ? vector : data_in;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Scoreboard bench for z80_bus_ctrl (IM2, base 8'h40, 2 mem / 1 io waits).
module tb_z80_bus_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic        cpu_rfsh_n;
    logic        cpu_m1_n;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_int_n;
    logic        cpu_wait_n;
    logic        pause;
    logic [15:0] adr;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic        io_rd;
    logic        io_wr;
    logic        mem_rd_stb;
    logic        mem_wr_stb;
    logic        io_rd_stb;
    logic        io_wr_stb;
    logic [3:0]  irq_req;
    logic [3:0]  irq_en;
    logic [3:0]  irq_ack;

    int n_chk;
    int n_err;
    logic [31:0] exp_q[$];

    z80_bus_ctrl #(
        .NUM_IRQ  (4),
        .IRQ_MODE (2),
        .VEC_BASE (8'h40),
        .WAIT_MEM (2),
        .WAIT_IO  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_rfsh_n (cpu_rfsh_n),
        .cpu_m1_n   (cpu_m1_n),
        .cpu_adr    (cpu_adr),
        .cpu_do     (cpu_do),
        .cpu_di     (cpu_di),
        .cpu_int_n  (cpu_int_n),
        .cpu_wait_n (cpu_wait_n),
        .pause      (pause),
        .adr        (adr),
        .data_out   (data_out),
        .data_in    (data_in),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .mem_rd_stb (mem_rd_stb),
        .mem_wr_stb (mem_wr_stb),
        .io_rd_stb  (io_rd_stb),
        .io_wr_stb  (io_wr_stb),
        .irq_req    (irq_req),
        .irq_en     (irq_en),
        .irq_ack    (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] got);
        logic [31:0] e;
        if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
        else e = exp_q.pop_front();
        chk(tag, got, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_rfsh_n = 1'b1;
        cpu_m1_n   = 1'b1;
    endtask

    function automatic logic [31:0] lv();
        return 32'({mem_rd, mem_wr, io_rd, io_wr});
    endfunction

    function automatic logic [31:0] stbs();
        return 32'({mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb});
    endfunction

    task automatic int_chk(input string tag, input logic e);
        push(32'(e));
        @(negedge clk);
        pop_chk(tag, 32'(cpu_int_n));
    endtask

    task automatic int_cyc(input string tag, input logic e);
        tick();
        int_chk(tag, e);
    endtask

    task automatic do_intack(input logic [7:0] vec, input logic [3:0] ack,
                             input logic [3:0] req_set);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                cpu_iorq_n = 1'b0;
                cpu_m1_n   = 1'b0;
                irq_req    = irq_req | req_set;
            end
            if (k == 3) idle();
            push(32'((k == 3) ? 8'hA5 : vec));
            push(32'((k == 1) ? ack : 4'b0000));
            @(negedge clk);
            pop_chk("ia_di", 32'(cpu_di));
            pop_chk("ia_ack", 32'(irq_ack));
        end
    endtask

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        idle();
        cpu_adr = 16'h0000;
        cpu_do  = 8'h00;
        pause   = 1'b0;
        data_in = 8'hA5;
        irq_req = 4'b0000;
        irq_en  = 4'hF;

        @(negedge clk);
        push(0); push(0); push(0); push(1); push(1);
        pop_chk("rst_lv", lv());
        pop_chk("rst_stb", stbs());
        pop_chk("rst_ack", 32'(irq_ack));
        pop_chk("rst_int", 32'(cpu_int_n));
        pop_chk("rst_wait", 32'(cpu_wait_n));
        tick();
        reset_n = 1'b1;
        tick();

        // memory read with two wait clocks
        tick();
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        cpu_adr    = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            push(32'(k == 0));
            push(32'(k >= 2));
            push(1);
            push(32'h0000_00A5);
            push(32'h0000_1234);
            @(negedge clk);
            pop_chk("mrd_stb", 32'(mem_rd_stb));
            pop_chk("mrd_wait", 32'(cpu_wait_n));
            pop_chk("mrd_lv", 32'(mem_rd));
            pop_chk("mrd_di", 32'(cpu_di));
            pop_chk("mrd_adr", 32'(adr));
        end
        tick();
        idle();
        tick();
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_do     = 8'h5A;
        push(32'b0100); push(32'h5A); push(0);
        @(negedge clk);
        pop_chk("mwr_stb", stbs());
        pop_chk("mwr_do", 32'(data_out));
        pop_chk("mwr_wait", 32'(cpu_wait_n));
        tick();
        idle();
        tick();
        tick();

        // refresh and interrupt-acknowledge must not qualify
        tick();
        cpu_mreq_n = 1'b0;
        cpu_rfsh_n = 1'b0;
        push(0); push(0);
        @(negedge clk);
        pop_chk("rf_lv", lv());
        pop_chk("rf_stb", stbs());
        tick();
        cpu_rd_n = 1'b0;
        push(0); push(0); push(1);
        @(negedge clk);
        pop_chk("rfrd_lv", lv());
        pop_chk("rfrd_stb", stbs());
        pop_chk("rfrd_wait", 32'(cpu_wait_n));
        tick();
        idle();
        tick();
        cpu_iorq_n = 1'b0;
        cpu_m1_n   = 1'b0;
        cpu_rd_n   = 1'b0;
        cpu_wr_n   = 1'b0;
        push(0); push(0); push(32'hFF); push(1);
        @(negedge clk);
        pop_chk("ia_lv", lv());
        pop_chk("ia_stb", stbs());
        pop_chk("spur_di", 32'(cpu_di));
        pop_chk("spur_wait", 32'(cpu_wait_n));
        tick();
        push(0);
        @(negedge clk);
        pop_chk("spur_ack", 32'(irq_ack));
        tick();
        idle();
        tick();

        // two channels rising together, serviced in priority order
        tick();
        irq_req = 4'b0110;
        int_chk("int_pre", 1'b1);
        int_cyc("int_edge", 1'b1);
        int_cyc("int_fall", 1'b0);
        do_intack(8'h42, 4'b0010, 4'b0000);
        do_intack(8'h44, 4'b0100, 4'b0000);
        int_chk("int_clr", 1'b1);

        // masked pending channel
        tick();
        irq_req = 4'b0000;
        irq_en  = 4'b1011;
        int_chk("msk_a", 1'b1);
        tick();
        irq_req = 4'b0100;
        int_chk("msk_b", 1'b1);
        int_cyc("msk_c", 1'b1);
        int_cyc("msk_d", 1'b1);
        tick();
        irq_en = 4'hF;
        int_chk("en_a", 1'b1);
        int_cyc("en_b", 1'b0);
        do_intack(8'h44, 4'b0100, 4'b0000);
        int_cyc("en_clr", 1'b1);

        // spurious acknowledge leaves a masked channel pending
        tick();
        irq_req = 4'b0000;
        irq_en  = 4'b0111;
        int_chk("sp_a", 1'b1);
        tick();
        irq_req = 4'b1000;
        int_chk("sp_b", 1'b1);
        int_cyc("sp_c", 1'b1);
        do_intack(8'hFF, 4'b0000, 4'b0000);
        int_cyc("sp_d", 1'b1);
        tick();
        irq_en = 4'hF;
        int_chk("sp_e", 1'b1);
        int_cyc("sp_f", 1'b0);
        do_intack(8'h46, 4'b1000, 4'b0000);
        int_cyc("sp_g", 1'b1);

        // new edge in the acknowledge clock of the same channel
        tick();
        irq_req = 4'b0000;
        int_chk("sw_a", 1'b1);
        tick();
        irq_req = 4'b0001;
        int_chk("sw_b", 1'b1);
        int_cyc("sw_c", 1'b1);
        tick();
        irq_req = 4'b0000;
        int_chk("sw_d", 1'b0);
        do_intack(8'h40, 4'b0001, 4'b0001);
        int_cyc("sw_e", 1'b0);
        do_intack(8'h40, 4'b0001, 4'b0000);
        int_cyc("sw_f", 1'b1);

        // io write stretched by pause, then reset mid-access
        tick();
        irq_req = 4'b0000;
        tick();
        irq_req = 4'b0010;
        int_cyc("io_int_a", 1'b1);
        int_cyc("io_int_b", 1'b0);
        tick();
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        cpu_do     = 8'h3C;
        pause      = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            if (k == 5) pause = 1'b0;
            push(32'(k == 0));
            push(32'(k >= 5));
            push(1);
            @(negedge clk);
            pop_chk("iow_stb", 32'(io_wr_stb));
            pop_chk("iow_wait", 32'(cpu_wait_n));
            pop_chk("iow_lv", 32'(io_wr));
        end
        pause = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        push(0); push(0); push(1); push(1); push(0);
        pop_chk("mr_lv", lv());
        pop_chk("mr_stb", stbs());
        pop_chk("mr_wait", 32'(cpu_wait_n));
        pop_chk("mr_int", 32'(cpu_int_n));
        pop_chk("mr_ack", 32'(irq_ack));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        push(1); push(1); push(0);
        pop_chk("rel_stb", 32'(io_wr_stb));
        pop_chk("rel_lv", 32'(io_wr));
        pop_chk("rel_wait", 32'(cpu_wait_n));
        tick();
        push(0);
        @(negedge clk);
        pop_chk("rel_stb2", 32'(io_wr_stb));
        tick();
        pause = 1'b0;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
- Parametrised bus-control shell placed between a T80-family core and the arcade board logic.
- Converts raw active-low Z80 control lines into qualified memory/IO levels and one-clock strobes, with refresh and interrupt-acknowledge filtering.
- Adds an N-channel latched, masked, priority interrupt controller supporting IM1 or IM2 vectoring, with acknowledge decoded from M1+IORQ rather than from the address bus.
- Adds programmable memory/IO wait-state insertion merged with an external pause.

Parameters:
- NUM_IRQ, 4, number of interrupt channels (1..8); channel 0 has the highest priority.
- IRQ_MODE, 1, 1 = IM1 (vector byte 8'hFF), 2 = IM2 (vector = VEC_BASE + 2*channel).
- VEC_BASE, 8'h00, IM2 vector base; bit 0 must be 0.
- WAIT_MEM, 0, wait clocks inserted per memory read/write (0..15).
- WAIT_IO, 1, wait clocks inserted per IO read/write (0..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_m1_n  in  1 each  raw core control lines.
- cpu_adr  in  16  core address.
- cpu_do  in  8  core write data.
- cpu_di  out  8  read data returned to the core.
- cpu_int_n  out  1  INT_n to the core.
- cpu_wait_n  out  1  WAIT_n to the core.
- pause  in  1  external hold; forces wait.
- adr  out  16  passthrough of cpu_adr.
- data_out  out  8  passthrough of cpu_do.
- data_in  in  8  board read data.
- mem_rd, mem_wr, io_rd, io_wr  out  1 each  qualified access levels.
- mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb  out  1 each  one-clock pulse on the first cycle of each access.
- irq_req  in  NUM_IRQ  interrupt sources; rising-edge sensitive.
- irq_en  in  NUM_IRQ  per-channel enable mask.
- irq_ack  out  NUM_IRQ  one-clock pulse to the channel being acknowledged.

Behaviour:
- Reset values:
  - All strobes, levels and irq_ack = 0.
  - cpu_int_n = 1, cpu_wait_n = 1, pending = 0.
  - Edge-detect and previous-access registers = 0, wait counter = 0.
- Qualification (combinational):
  - mem_x = !mreq_n & rfsh_n & !x_n.
  - io_x = !iorq_n & m1_n & !x_n.
  - intack = !iorq_n & !m1_n.
  - Refresh cycles and intack never raise mem/io outputs.
- Strobes: x_stb = x & !x_prev, where x_prev is registered. One pulse per access, however long the access is held by wait.
- Wait generation:
  - On a strobe cycle, load the counter with WAIT_sel-1 when WAIT_sel > 0.
  - cpu_wait_n = !(pause | (strobe & WAIT_sel>0) | counter!=0). The counter decrements every clock while nonzero.
  - Result: exactly WAIT_sel low clocks starting in the strobe clock.
  - pause only extends the low period; the counter keeps decrementing under pause.
  - WAIT_sel = 0 inserts no wait.
- Interrupt pending:
  - Bit i sets on an irq_req[i] 0->1 edge (registered edge detect).
  - Bit i clears on acknowledge of channel i.
  - Set and clear in the same clock on the same bit: set wins.
  - Masked channels stay pending but do not contribute.
  - cpu_int_n = !(|(pending & irq_en)), registered.
- Acknowledge:
  - On the first clock of intack, latch win = lowest index of pending & irq_en.
  - Clear that pending bit and pulse irq_ack[win] for one clock.
  - Hold the vector until intack falls.
  - If no channel qualifies (spurious), no ack is pulsed and the vector is 8'hFF.
  - A new edge during intack is registered and will be serviced later.
- Read data: cpu_di = intack ? vector : data_in.
- Reset mid-access: outputs return to reset values immediately. A subsequent access after reset release generates a fresh strobe only if the access is still active, because x_prev was cleared.

Decomposition:
- Include file z80_bus_defs.vh holds:
  - IRQ_MODE_IM1 and IRQ_MODE_IM2 constants.
  - SPURIOUS_VEC = 8'hFF.
  - A priority-encoder function.
- Natural sub-module: z80_irq_ctrl, covering edge detect, pending, mask, priority, vector and ack.
- Bus qualification and wait logic stay in the top level.

Test Plan:
- Memory read at 16'h1234, WAIT_MEM=2 -> mem_rd_stb high for exactly one clock; cpu_wait_n low for exactly 2 clocks starting on the strobe clock; mem_rd high throughout; cpu_di = data_in.
- Refresh cycle (mreq_n=0, rfsh_n=0, rd_n=1) and M1+IORQ cycle -> mem_*, io_*, and all strobes stay 0.
- irq_req 4'b0110 rising together, irq_en=4'hF, IRQ_MODE=2, VEC_BASE=8'h40 -> cpu_int_n falls one clock later. First intack gives cpu_di=8'h42 and irq_ack=4'b0010. Second intack gives 8'h44 and irq_ack=4'b0100. cpu_int_n then returns to 1.
- Channel 2 pending with irq_en[2]=0 -> cpu_int_n stays 1. Enabling it -> cpu_int_n falls on the next clock.
- Forced intack with nothing qualified -> cpu_di=8'hFF, no irq_ack pulse, pending unchanged.
- IO write with WAIT_IO=1 and pause held for 5 clocks -> io_wr_stb single pulse; cpu_wait_n low for 5 clocks, then high once pause drops; reset_n pulsed mid-access -> all outputs return to reset values immediately.
